// File: rtl/pe_seq_ctrl_pkg.sv
// Shared definitions for the pe_seq_ctrl convolution PE sequencer.
package pe_seq_ctrl_pkg;

  localparam int unsigned KNL_SIZE   = 25;
  localparam int unsigned KNL_MAXNUM = 16;
  localparam int unsigned KNL_COL    = 5;

  // Issue-to-en_mac and issue-to-out_valid pipeline depths
  localparam int unsigned MAC_DLY = 2;
  localparam int unsigned OUT_DLY = 3;

  // Wide enough for a full kernel bank load (16 * 25 = 400 words)
  localparam int unsigned WCNT_W = 9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LD_KNL,
    ST_LD_IFMAP,
    ST_SWEEP,
    ST_DRAIN,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic       valid;
    logic [3:0] chnl;
  } issue_t;

  function automatic logic [WCNT_W-1:0] knl_words(input logic [4:0] n);
    return WCNT_W'(n) * WCNT_W'(KNL_SIZE);
  endfunction

  function automatic logic num_knls_ok(input logic [4:0] n);
    return (n != 5'd0) && (n <= 5'(KNL_MAXNUM));
  endfunction

endpackage

// File: rtl/pe_seq_ctrl_if.sv
// Host/PE-side bundle of pe_seq_ctrl. Optional perf counters under PE_SEQ_CTRL_PERF_EN.
interface pe_seq_ctrl_if #(
  parameter int unsigned DIM_WIDTH = 8
) ();

  logic                 start;
  logic [4:0]           cfg_num_knls;
  logic                 cfg_ld_knl;
  logic                 cfg_first_chnl;
  logic [DIM_WIDTH-1:0] cfg_win_cols;
  logic [DIM_WIDTH-1:0] cfg_win_rows;
  logic                 in_valid;
  logic                 in_ready;
  logic                 en_ld_knl;
  logic                 en_ld_ifmap;
  logic [4:0]           num_knls;
  logic [3:0]           cnt_ofmap_chnl;
  logic                 en_mac;
  logic                 disable_acc;
  logic                 data_sel;
  logic                 psum_rd_req;
  logic [3:0]           psum_rd_chnl;
  logic                 out_valid;
  logic [3:0]           out_chnl;
  logic [DIM_WIDTH-1:0] out_win_col;
  logic [DIM_WIDTH-1:0] out_win_row;
  logic                 busy;
  logic                 done;
`ifdef PE_SEQ_CTRL_PERF_EN
  logic [31:0]          perf_stall_cnt;
  logic [31:0]          perf_mac_cnt;
`endif

  // Controller side
  modport master (
    input  start, cfg_num_knls, cfg_ld_knl, cfg_first_chnl, cfg_win_cols, cfg_win_rows, in_valid,
    output in_ready, en_ld_knl, en_ld_ifmap, num_knls, cnt_ofmap_chnl, en_mac, disable_acc,
           data_sel, psum_rd_req, psum_rd_chnl, out_valid, out_chnl, out_win_col, out_win_row,
           busy, done
`ifdef PE_SEQ_CTRL_PERF_EN
    , output perf_stall_cnt, perf_mac_cnt
`endif
  );

  // Host / PE side
  modport slave (
    output start, cfg_num_knls, cfg_ld_knl, cfg_first_chnl, cfg_win_cols, cfg_win_rows, in_valid,
    input  in_ready, en_ld_knl, en_ld_ifmap, num_knls, cnt_ofmap_chnl, en_mac, disable_acc,
           data_sel, psum_rd_req, psum_rd_chnl, out_valid, out_chnl, out_win_col, out_win_row,
           busy, done
`ifdef PE_SEQ_CTRL_PERF_EN
    , input perf_stall_cnt, perf_mac_cnt
`endif
  );

endinterface

// File: rtl/pe_seq_pipe.sv
// Channel-issue delay line: turns a SWEEP issue into en_mac/psum read and out_valid beats.
module pe_seq_pipe
  import pe_seq_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       srstn,
  input  logic       issue_valid,
  input  logic [3:0] issue_chnl,
  input  logic       disable_acc,
  output logic       en_mac,
  output logic       psum_rd_req,
  output logic [3:0] psum_rd_chnl,
  output logic       out_valid,
  output logic [3:0] out_chnl,
  output logic       data_sel
);

  issue_t stage [OUT_DLY];
  issue_t mac_s;
  issue_t out_s;

  // Shift the issued {valid, chnl} one stage per cycle
  always_ff @(posedge clk) begin
    if (!srstn) begin
      for (int unsigned i = 0; i < OUT_DLY; i++) stage[i] <= '0;
    end else begin
      stage[0] <= '{valid: issue_valid, chnl: issue_chnl};
      for (int unsigned i = 1; i < OUT_DLY; i++) stage[i] <= stage[i-1];
    end
  end

  assign mac_s = stage[MAC_DLY-1];
  assign out_s = stage[OUT_DLY-1];

  assign en_mac       = mac_s.valid;
  assign psum_rd_req  = mac_s.valid & ~disable_acc;
  assign psum_rd_chnl = mac_s.valid ? mac_s.chnl : '0;
  assign out_valid    = out_s.valid;
  assign out_chnl     = out_s.valid ? out_s.chnl : '0;
  assign data_sel     = out_s.valid & ~disable_acc;

endmodule

// File: rtl/pe_seq_ctrl.sv
// Convolution PE sequencer: kernel load, windowed ifmap loads, per-channel sweeps.
// Optional perf counters enabled by defining PE_SEQ_CTRL_PERF_EN.
module pe_seq_ctrl
  import pe_seq_ctrl_pkg::*;
#(
  parameter int unsigned DIM_WIDTH = 8
) (
  input  logic          clk,
  input  logic          srstn,
  pe_seq_ctrl_if.master bus
);

  state_t               state;
  state_t               state_nxt;
  logic [WCNT_W-1:0]    cnt;
  logic [WCNT_W-1:0]    load_len;
  logic [4:0]           num_knls_q;
  logic                 first_q;
  logic [DIM_WIDTH-1:0] cols_q;
  logic [DIM_WIDTH-1:0] rows_q;
  logic [DIM_WIDTH-1:0] col_q;
  logic [DIM_WIDTH-1:0] row_q;
  logic [3:0]           chnl_q;
  logic                 start_ok;
  logic                 loading;
  logic                 word_acc;
  logic                 load_last;
  logic                 sweep_last;
  logic                 drain_last;
  logic                 more_cols;
  logic                 more_rows;
  logic                 in_ready;
  logic                 en_ld_knl;
  logic                 en_ld_ifmap;
  logic                 done;
  logic                 en_mac;
  logic                 psum_rd_req;
  logic [3:0]           psum_rd_chnl;
  logic                 out_valid;
  logic [3:0]           out_chnl;
  logic                 data_sel;

  assign start_ok   = (state == ST_IDLE) && bus.start;
  assign loading    = (state == ST_LD_KNL) || (state == ST_LD_IFMAP);
  assign word_acc   = loading && bus.in_valid;
  assign load_len   = (state == ST_LD_KNL) ? knl_words(num_knls_q) :
                      (col_q == '0)        ? WCNT_W'(KNL_SIZE) : WCNT_W'(KNL_COL);
  assign load_last  = (cnt == load_len - WCNT_W'(1));
  assign sweep_last = ({1'b0, chnl_q} == num_knls_q - 5'd1);
  assign drain_last = (cnt == WCNT_W'(OUT_DLY - 1));
  assign more_cols  = (col_q < cols_q - DIM_WIDTH'(1));
  assign more_rows  = (row_q < rows_q - DIM_WIDTH'(1));

  // State register
  always_ff @(posedge clk) begin
    if (!srstn) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state and per-state load/handshake outputs
  always_comb begin
    state_nxt   = state;
    in_ready    = 1'b0;
    en_ld_knl   = 1'b0;
    en_ld_ifmap = 1'b0;
    done        = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (bus.start) begin
          if (!num_knls_ok(bus.cfg_num_knls)) state_nxt = ST_DONE;
          else if (bus.cfg_ld_knl)            state_nxt = ST_LD_KNL;
          else                                state_nxt = ST_LD_IFMAP;
        end
      end
      ST_LD_KNL: begin
        in_ready  = 1'b1;
        en_ld_knl = bus.in_valid;
        if (bus.in_valid && load_last) state_nxt = ST_LD_IFMAP;
      end
      ST_LD_IFMAP: begin
        in_ready    = 1'b1;
        en_ld_ifmap = bus.in_valid;
        if (bus.in_valid && load_last) state_nxt = ST_SWEEP;
      end
      ST_SWEEP: begin
        if (sweep_last) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (drain_last) state_nxt = (more_cols || more_rows) ? ST_LD_IFMAP : ST_DONE;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Shared counter: accepted load words, then drain cycles
  always_ff @(posedge clk) begin
    if (!srstn)                  cnt <= '0;
    else if (word_acc)           cnt <= load_last ? '0 : cnt + WCNT_W'(1);
    else if (state == ST_DRAIN)  cnt <= drain_last ? '0 : cnt + WCNT_W'(1);
  end

  // Job configuration captured on an accepted start
  always_ff @(posedge clk) begin
    if (!srstn) begin
      num_knls_q <= '0;
      first_q    <= 1'b0;
      cols_q     <= '0;
      rows_q     <= '0;
    end else if (start_ok) begin
      num_knls_q <= bus.cfg_num_knls;
      first_q    <= bus.cfg_first_chnl;
      cols_q     <= bus.cfg_win_cols;
      rows_q     <= bus.cfg_win_rows;
    end
  end

  // Window position, advanced only when a drain completes
  always_ff @(posedge clk) begin
    if (!srstn || start_ok) begin
      col_q <= '0;
      row_q <= '0;
    end else if (state == ST_DRAIN && drain_last) begin
      if (more_cols) begin
        col_q <= col_q + DIM_WIDTH'(1);
      end else if (more_rows) begin
        col_q <= '0;
        row_q <= row_q + DIM_WIDTH'(1);
      end
    end
  end

  // Channel issue counter; holds its last value outside SWEEP
  always_ff @(posedge clk) begin
    if (!srstn)                                            chnl_q <= '0;
    else if (state == ST_LD_IFMAP && state_nxt == ST_SWEEP) chnl_q <= '0;
    else if (state == ST_SWEEP && !sweep_last)              chnl_q <= chnl_q + 4'd1;
  end

  pe_seq_pipe u_pipe (
    .clk          (clk),
    .srstn        (srstn),
    .issue_valid  (state == ST_SWEEP),
    .issue_chnl   (chnl_q),
    .disable_acc  (first_q),
    .en_mac       (en_mac),
    .psum_rd_req  (psum_rd_req),
    .psum_rd_chnl (psum_rd_chnl),
    .out_valid    (out_valid),
    .out_chnl     (out_chnl),
    .data_sel     (data_sel)
  );

  assign bus.in_ready       = in_ready;
  assign bus.en_ld_knl      = en_ld_knl;
  assign bus.en_ld_ifmap    = en_ld_ifmap;
  assign bus.num_knls       = num_knls_q;
  assign bus.cnt_ofmap_chnl = chnl_q;
  assign bus.en_mac         = en_mac;
  assign bus.disable_acc    = first_q;
  assign bus.data_sel       = data_sel;
  assign bus.psum_rd_req    = psum_rd_req;
  assign bus.psum_rd_chnl   = psum_rd_chnl;
  assign bus.out_valid      = out_valid;
  assign bus.out_chnl       = out_chnl;
  assign bus.out_win_col    = col_q;
  assign bus.out_win_row    = row_q;
  assign bus.busy           = (state != ST_IDLE);
  assign bus.done           = done;

`ifdef PE_SEQ_CTRL_PERF_EN
  logic [31:0] stall_cnt;
  logic [31:0] mac_cnt;

  // Load-stall and MAC-cycle counters, cleared per job
  always_ff @(posedge clk) begin
    if (!srstn || start_ok) begin
      stall_cnt <= '0;
      mac_cnt   <= '0;
    end else begin
      if (loading && !bus.in_valid) stall_cnt <= stall_cnt + 32'd1;
      if (en_mac)                   mac_cnt   <= mac_cnt + 32'd1;
    end
  end

  assign bus.perf_stall_cnt = stall_cnt;
  assign bus.perf_mac_cnt   = mac_cnt;
`endif

endmodule

// File: tb/tb_pe_seq_ctrl.sv
// Self-checking bench for pe_seq_ctrl: table-driven jobs, hand sequences, random jobs.
module tb_pe_seq_ctrl;

  localparam int DW = 8;

  logic clk = 1'b0;
  logic srstn = 1'b0;

  pe_seq_ctrl_if #(.DIM_WIDTH(DW)) bus ();

  pe_seq_ctrl #(.DIM_WIDTH(DW)) dut (
    .clk   (clk),
    .srstn (srstn),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [4:0] n;
    bit         ld;
    bit         first;
    int         cols;
    int         rows;
    int         mode;       // 0: in_valid=1, 1: toggling, 2: random
    bit         poke;       // pulse start mid-job
    int         exp_knl;
    int         exp_beats;
    int         exp_lat;    // cycles from start edge to done; 0 = not checked
  } job_t;

  job_t tbl [7];

  function automatic void check(input string name, input longint got, input longint exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endfunction

  function automatic longint outs();
    return longint'({bus.in_ready, bus.en_ld_knl, bus.en_ld_ifmap, bus.num_knls,
                     bus.cnt_ofmap_chnl, bus.en_mac, bus.disable_acc, bus.data_sel,
                     bus.psum_rd_req, bus.psum_rd_chnl, bus.out_valid, bus.out_chnl,
                     bus.out_win_col, bus.out_win_row, bus.busy, bus.done});
  endfunction

  task automatic run_job(input job_t j);
    int cyc = 0, knl = 0, cur = 0, rdy = 0;
    bit done_seen = 0, prev_mac = 0, prev_rdy = 0, valid_n;
    logic [3:0] prev_prch = '0, h0 = '0, h1 = '0, h2 = '0;
    int exp_lens[$], exp_beats[$], got_lens[$], got_beats[$];
    valid_n = (j.n != 5'd0) && (j.n <= 5'd16);
    if (valid_n)
      for (int r = 0; r < j.rows; r++)
        for (int c = 0; c < j.cols; c++) begin
          exp_lens.push_back(c == 0 ? 25 : 5);
          for (int k = 0; k < int'(j.n); k++) exp_beats.push_back(k + 16*c + 4096*r);
        end
    @(posedge clk); #1;
    bus.cfg_num_knls   = j.n;
    bus.cfg_ld_knl     = j.ld;
    bus.cfg_first_chnl = j.first;
    bus.cfg_win_cols   = 8'(j.cols);
    bus.cfg_win_rows   = 8'(j.rows);
    bus.in_valid       = 1'b0;
    bus.start          = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    // cfg must be ignored after the start has been taken
    bus.cfg_num_knls   = 5'($urandom);
    bus.cfg_ld_knl     = 1'($urandom);
    bus.cfg_first_chnl = 1'($urandom);
    bus.cfg_win_cols   = 8'($urandom);
    bus.cfg_win_rows   = 8'($urandom);
    while (!done_seen && cyc < 5000) begin
      bus.start = j.poke && (cyc == 10);
      case (j.mode)
        0:       bus.in_valid = 1'b1;
        1:       bus.in_valid = (cyc % 2) == 1;
        default: bus.in_valid = $urandom_range(0, 3) != 0;
      endcase
      @(negedge clk);
      cyc++;
      if (cyc == 1 && valid_n) begin
        check("num_knls", bus.num_knls, j.n);
        check("disable_acc", bus.disable_acc, j.first);
      end
      check("ld_gate", (bus.en_ld_knl | bus.en_ld_ifmap) & ~bus.in_valid, 0);
      check("mac_to_out", bus.out_valid, prev_mac);
      check("psum_req", bus.psum_rd_req, bus.en_mac & ~j.first);
      check("data_sel", bus.data_sel, bus.out_valid & ~j.first);
      if (bus.out_valid) begin
        check("out_chnl_vs_issue", bus.out_chnl, h2);
        if (!j.first) check("psum_chnl", prev_prch, bus.out_chnl);
        got_beats.push_back(int'(bus.out_chnl) + 16*int'(bus.out_win_col) + 4096*int'(bus.out_win_row));
      end
      knl += int'(bus.en_ld_knl);
      cur += int'(bus.en_ld_ifmap);
      rdy += int'(bus.in_ready);
      if (prev_rdy && !bus.in_ready) begin
        got_lens.push_back(cur);
        cur = 0;
      end
      prev_rdy  = bus.in_ready;
      prev_mac  = bus.en_mac;
      prev_prch = bus.psum_rd_chnl;
      h2 = h1; h1 = h0; h0 = bus.cnt_ofmap_chnl;
      if (bus.done) done_seen = 1;
      else begin @(posedge clk); #1; end
    end
    bus.start = 1'b0;
    check("done_seen", done_seen, 1);
    @(negedge clk);
    check("idle_after_done", {bus.busy, bus.done}, 0);
    check("knl_words", knl, j.exp_knl);
    check("beat_count", got_beats.size(), j.exp_beats);
    check("load_count", got_lens.size(), exp_lens.size());
    for (int i = 0; i < got_lens.size() && i < exp_lens.size(); i++)
      check("load_len", got_lens[i], exp_lens[i]);
    for (int i = 0; i < got_beats.size() && i < exp_beats.size(); i++)
      check("beat", got_beats[i], exp_beats[i]);
    if (j.exp_lat != 0) check("latency", cyc, j.exp_lat);
    check("non_load_cycles", cyc - rdy, valid_n ? j.rows * j.cols * (int'(j.n) + 3) + 1 : 1);
  endtask

  initial begin
    job_t rj;
    bus.start = 1'b0;
    bus.cfg_num_knls = '0;
    bus.cfg_ld_knl = 1'b0;
    bus.cfg_first_chnl = 1'b0;
    bus.cfg_win_cols = '0;
    bus.cfg_win_rows = '0;
    bus.in_valid = 1'b0;

    // n, ld, first, cols, rows, mode, poke, knl words, beats, latency
    tbl[0] = '{5'd3,  1'b1, 1'b1, 1, 1, 0, 1'b0, 75,  3,  107};
    tbl[1] = '{5'd1,  1'b0, 1'b1, 3, 2, 0, 1'b0, 0,   6,  95};
    tbl[2] = '{5'd2,  1'b0, 1'b0, 2, 1, 0, 1'b0, 0,   4,  41};
    tbl[3] = '{5'd16, 1'b1, 1'b0, 1, 1, 1, 1'b0, 400, 16, 0};
    tbl[4] = '{5'd0,  1'b1, 1'b0, 1, 1, 0, 1'b0, 0,   0,  1};
    tbl[5] = '{5'd17, 1'b1, 1'b0, 1, 1, 0, 1'b0, 0,   0,  1};
    tbl[6] = '{5'd4,  1'b1, 1'b1, 1, 2, 0, 1'b1, 100, 8,  165};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", outs(), 0);
    srstn = 1'b1;

    for (int i = 0; i < 7; i++) run_job(tbl[i]);

    // Reset asserted mid-SWEEP (LD_IFMAP cycles 1..25, SWEEP from cycle 26)
    @(posedge clk); #1;
    bus.cfg_num_knls = 5'd4;
    bus.cfg_ld_knl = 1'b0;
    bus.cfg_first_chnl = 1'b0;
    bus.cfg_win_cols = 8'd1;
    bus.cfg_win_rows = 8'd1;
    bus.in_valid = 1'b1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (27) @(negedge clk);
    check("sweep_busy", bus.busy, 1);
    check("sweep_chnl", bus.cnt_ofmap_chnl, 1);
    srstn = 1'b0;
    @(negedge clk);
    check("reset_mid_sweep", outs(), 0);
    srstn = 1'b1;
    bus.in_valid = 1'b0;
    run_job(tbl[0]);

    // Random jobs against the window/channel model
    for (int i = 0; i < 12; i++) begin
      if ($urandom_range(0, 5) == 0) rj.n = ($urandom_range(0, 1) == 0) ? 5'd0 : 5'($urandom_range(17, 31));
      else                           rj.n = 5'($urandom_range(1, 16));
      rj.ld    = 1'($urandom);
      rj.first = 1'($urandom);
      rj.cols  = int'($urandom_range(1, 3));
      rj.rows  = int'($urandom_range(1, 3));
      rj.mode  = 2;
      rj.poke  = 1'($urandom);
      if (rj.n != 5'd0 && rj.n <= 5'd16) begin
        rj.exp_knl   = rj.ld ? int'(rj.n) * 25 : 0;
        rj.exp_beats = int'(rj.n) * rj.cols * rj.rows;
      end else begin
        rj.exp_knl   = 0;
        rj.exp_beats = 0;
      end
      rj.exp_lat = 0;
      run_job(rj);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
